// File: rtl/sprite_fetch_scheduler.sv
// sprite_fetch_scheduler
// Shares one synchronous sprite ROM between NUM_SLOTS sprite slots. Each pixel
// picks the lowest-index enabled slot that covers (DrawX, DrawY) and issues one
// ROM read for it. Slot configuration is written into a shadow copy and moved
// to the active copy only on frame_start, so a sprite cannot tear mid-frame.
// Pipeline: inputs -> rom_address/sideband -> rom_q/sideband -> pix_* outputs.

module sprite_fetch_scheduler #(
    parameter int NUM_SLOTS = 8,
    parameter int IMG_BITS  = 3,
    parameter int SPR_DIM   = 32
) (
    input  logic                   vga_clk,
    input  logic                   reset,
    input  logic [9:0]             DrawX,
    input  logic [9:0]             DrawY,
    input  logic                   blank,
    input  logic                   frame_start,
    input  logic                   cfg_we,
    input  logic [2:0]             cfg_slot,
    input  logic [1:0]             cfg_field,
    input  logic [9:0]             cfg_wdata,
    output logic [IMG_BITS+9:0]    rom_address,
    input  logic [7:0]             rom_q,
    output logic [7:0]             pix_index,
    output logic                   pix_hit,
    output logic [2:0]             pix_slot,
    output logic                   blank_out,
    output logic [NUM_SLOTS-1:0]   collision_mask
);

    // Sprite side length is a power of two; row/col use the low DIM_BITS bits.
    localparam int DIM_BITS = $clog2(SPR_DIM);
    localparam logic [3:0]           NUM_SLOTS_L = 4'(NUM_SLOTS);
    localparam logic [10:0]          SPR_DIM_L   = 11'(SPR_DIM);
    localparam logic [NUM_SLOTS-1:0] ONE_L       = NUM_SLOTS'(1);

    // Shadow (CPU-written) and active (used for drawing) slot configuration.
    logic [9:0]          r_sh_x   [NUM_SLOTS];
    logic [9:0]          r_sh_y   [NUM_SLOTS];
    logic [IMG_BITS-1:0] r_sh_img [NUM_SLOTS];
    logic                r_sh_en  [NUM_SLOTS];
    logic [9:0]          r_ac_x   [NUM_SLOTS];
    logic [9:0]          r_ac_y   [NUM_SLOTS];
    logic [IMG_BITS-1:0] r_ac_img [NUM_SLOTS];
    logic                r_ac_en  [NUM_SLOTS];

    // Shadow contents after this cycle's write (what a frame_start commits).
    logic [9:0]          w_nx_x   [NUM_SLOTS];
    logic [9:0]          w_nx_y   [NUM_SLOTS];
    logic [IMG_BITS-1:0] w_nx_img [NUM_SLOTS];
    logic                w_nx_en  [NUM_SLOTS];
    logic                w_wr_ok;

    // Hit test and arbitration.
    logic [10:0]          w_x_end [NUM_SLOTS];
    logic [10:0]          w_y_end [NUM_SLOTS];
    logic [DIM_BITS-1:0]  w_col   [NUM_SLOTS];
    logic [DIM_BITS-1:0]  w_row   [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] w_hit;
    logic                 w_any;
    logic [2:0]           w_win;
    logic [IMG_BITS+9:0]  w_addr;

    // Collision detection.
    logic                 w_multi;
    logic [NUM_SLOTS-1:0] w_coll;
    logic [NUM_SLOTS-1:0] r_coll_acc;

    // Pipeline sideband.
    logic       r_any1;
    logic [2:0] r_slot1;
    logic       r_blank1;
    logic       r_any2;
    logic [2:0] r_slot2;
    logic       r_blank2;
    logic       w_pix_hit;

    assign w_wr_ok = cfg_we && ({1'b0, cfg_slot} < NUM_SLOTS_L);

    // Merge the incoming config write into the shadow view of every slot.
    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            w_nx_x[i]   = r_sh_x[i];
            w_nx_y[i]   = r_sh_y[i];
            w_nx_img[i] = r_sh_img[i];
            w_nx_en[i]  = r_sh_en[i];
            if (w_wr_ok && (cfg_slot == 3'(i))) begin
                case (cfg_field)
                    2'd0:    w_nx_x[i]   = cfg_wdata;
                    2'd1:    w_nx_y[i]   = cfg_wdata;
                    2'd2:    w_nx_img[i] = cfg_wdata[IMG_BITS-1:0];
                    2'd3:    w_nx_en[i]  = cfg_wdata[0];
                    default: w_nx_en[i]  = r_sh_en[i];
                endcase
            end else begin
                w_nx_en[i] = r_sh_en[i];
            end
        end
    end

    // Shadow takes every write; active copies the merged shadow at frame_start.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_sh_x[i]   <= 10'd0;
                r_sh_y[i]   <= 10'd0;
                r_sh_img[i] <= '0;
                r_sh_en[i]  <= 1'b0;
                r_ac_x[i]   <= 10'd0;
                r_ac_y[i]   <= 10'd0;
                r_ac_img[i] <= '0;
                r_ac_en[i]  <= 1'b0;
            end
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_sh_x[i]   <= w_nx_x[i];
                r_sh_y[i]   <= w_nx_y[i];
                r_sh_img[i] <= w_nx_img[i];
                r_sh_en[i]  <= w_nx_en[i];
                if (frame_start) begin
                    r_ac_x[i]   <= w_nx_x[i];
                    r_ac_y[i]   <= w_nx_y[i];
                    r_ac_img[i] <= w_nx_img[i];
                    r_ac_en[i]  <= w_nx_en[i];
                end else begin
                    r_ac_x[i]   <= r_ac_x[i];
                    r_ac_y[i]   <= r_ac_y[i];
                    r_ac_img[i] <= r_ac_img[i];
                    r_ac_en[i]  <= r_ac_en[i];
                end
            end
        end
    end

    // Per-slot coverage test; end coordinates use 11 bits so x near 1023 cannot wrap.
    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            w_x_end[i] = {1'b0, r_ac_x[i]} + SPR_DIM_L;
            w_y_end[i] = {1'b0, r_ac_y[i]} + SPR_DIM_L;
            w_col[i]   = DrawX[DIM_BITS-1:0] - r_ac_x[i][DIM_BITS-1:0];
            w_row[i]   = DrawY[DIM_BITS-1:0] - r_ac_y[i][DIM_BITS-1:0];
            w_hit[i]   = r_ac_en[i]
                       & (DrawX >= r_ac_x[i]) & ({1'b0, DrawX} < w_x_end[i])
                       & (DrawY >= r_ac_y[i]) & ({1'b0, DrawY} < w_y_end[i]);
        end
    end

    // Lowest-index hitting slot wins; a transparent winner does not fall through.
    always_comb begin
        w_win = 3'd0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            w_win = w_hit[i] ? 3'(i) : w_win;
        end
        w_any   = |w_hit;
        w_addr  = {r_ac_img[w_win], w_row[w_win], w_col[w_win]};
        w_multi = |(w_hit & (w_hit - ONE_L));
        w_coll  = (blank && w_multi) ? w_hit : '0;
    end

    assign w_pix_hit = r_any2 & r_blank2 & (rom_q != 8'd0);

    // Three-stage pixel pipeline: address issue, ROM access, output register.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            rom_address <= '0;
            r_any1      <= 1'b0;
            r_slot1     <= 3'd0;
            r_blank1    <= 1'b0;
            r_any2      <= 1'b0;
            r_slot2     <= 3'd0;
            r_blank2    <= 1'b0;
            pix_hit     <= 1'b0;
            pix_index   <= 8'd0;
            pix_slot    <= 3'd0;
            blank_out   <= 1'b0;
        end else begin
            if (w_any) begin
                rom_address <= w_addr;
            end else begin
                rom_address <= rom_address;
            end
            r_any1    <= w_any;
            r_slot1   <= w_win;
            r_blank1  <= blank;
            r_any2    <= r_any1;
            r_slot2   <= r_slot1;
            r_blank2  <= r_blank1;
            pix_hit   <= w_pix_hit;
            pix_index <= w_pix_hit ? rom_q : 8'd0;
            pix_slot  <= r_any2 ? r_slot2 : 3'd0;
            blank_out <= r_blank2;
        end
    end

    // Accumulate overlaps during the frame; publish and clear at frame_start.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            r_coll_acc     <= '0;
            collision_mask <= '0;
        end else if (frame_start) begin
            collision_mask <= r_coll_acc | w_coll;
            r_coll_acc     <= '0;
        end else begin
            collision_mask <= collision_mask;
            r_coll_acc     <= r_coll_acc | w_coll;
        end
    end

endmodule

// File: tb/tb_sprite_fetch_scheduler.sv
// Directed bench for sprite_fetch_scheduler with a behavioural ROM and a
// scoreboard queue of expected pixel outputs.

module tb_sprite_fetch_scheduler;

    logic        vga_clk = 1'b0;
    logic        reset;
    logic [9:0]  DrawX, DrawY;
    logic        blank, frame_start, cfg_we;
    logic [2:0]  cfg_slot;
    logic [1:0]  cfg_field;
    logic [9:0]  cfg_wdata;
    logic [12:0] rom_address;
    logic [7:0]  rom_q;
    logic [7:0]  pix_index;
    logic        pix_hit;
    logic [2:0]  pix_slot;
    logic        blank_out;
    logic [7:0]  collision_mask;

    typedef struct packed {
        logic       hit;
        logic [7:0] idx;
        logic [2:0] slot;
        logic       blk;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Model state: shadow and active slot config, collision accumulator.
    int          m_sx[8], m_sy[8], m_simg[8];
    bit          m_sen[8];
    int          m_ax[8], m_ay[8], m_aimg[8];
    bit          m_aen[8];
    logic [7:0]  m_acc;
    logic [12:0] exp_addr;

    sprite_fetch_scheduler dut (
        .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY),
        .blank(blank), .frame_start(frame_start), .cfg_we(cfg_we),
        .cfg_slot(cfg_slot), .cfg_field(cfg_field), .cfg_wdata(cfg_wdata),
        .rom_address(rom_address), .rom_q(rom_q), .pix_index(pix_index),
        .pix_hit(pix_hit), .pix_slot(pix_slot), .blank_out(blank_out),
        .collision_mask(collision_mask)
    );

    always #5 vga_clk = ~vga_clk;

    // ROM contents: one known entry, image 7 fully transparent, others nonzero.
    function automatic logic [7:0] rom_fn(input logic [12:0] a);
        if (a == 13'd2373) return 8'h17;
        else if (a[12:10] == 3'd7) return 8'h00;
        else return {a[7:1], 1'b1};
    endfunction

    // Synchronous ROM: data valid one cycle after the address.
    always @(posedge vga_clk) rom_q <= rom_fn(rom_address);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 8; i++) begin
            m_sx[i] = 0; m_sy[i] = 0; m_simg[i] = 0; m_sen[i] = 1'b0;
            m_ax[i] = 0; m_ay[i] = 0; m_aimg[i] = 0; m_aen[i] = 1'b0;
        end
        m_acc = 8'd0;
        exp_addr = 13'd0;
        sb.delete();
    endtask

    // One clock with the currently driven inputs; model predicts, then checks.
    task automatic step();
        logic [7:0]  hits;
        logic [7:0]  mexp;
        logic [12:0] a;
        logic [7:0]  d;
        int          win, n, dx, dy;
        bit          any, fs;
        exp_t        e;
        dx = int'(DrawX);
        dy = int'(DrawY);
        hits = 8'd0;
        for (int i = 0; i < 8; i++)
            if (m_aen[i] && dx >= m_ax[i] && dx < m_ax[i] + 32 && dy >= m_ay[i] && dy < m_ay[i] + 32)
                hits[i] = 1'b1;
        any = (hits != 8'd0);
        win = 0;
        for (int i = 7; i >= 0; i--) if (hits[i]) win = i;
        a = 13'(m_aimg[win] * 1024 + (dy - m_ay[win]) * 32 + (dx - m_ax[win]));
        d = rom_fn(a);
        e.hit  = any && blank && (d != 8'd0);
        e.idx  = e.hit ? d : 8'd0;
        e.slot = any ? 3'(win) : 3'd0;
        e.blk  = blank;
        sb.push_back(e);
        if (any) exp_addr = a;
        n = 0;
        for (int i = 0; i < 8; i++) n += int'(hits[i]);
        if (blank && n >= 2) m_acc = m_acc | hits;
        if (cfg_we && int'(cfg_slot) < 8) begin
            case (cfg_field)
                2'd0: m_sx[cfg_slot]   = int'(cfg_wdata);
                2'd1: m_sy[cfg_slot]   = int'(cfg_wdata);
                2'd2: m_simg[cfg_slot] = int'(cfg_wdata[2:0]);
                default: m_sen[cfg_slot] = cfg_wdata[0];
            endcase
        end
        fs = frame_start;
        mexp = m_acc;
        if (fs) begin
            m_acc = 8'd0;
            for (int i = 0; i < 8; i++) begin
                m_ax[i] = m_sx[i]; m_ay[i] = m_sy[i];
                m_aimg[i] = m_simg[i]; m_aen[i] = m_sen[i];
            end
        end
        @(posedge vga_clk);
        #1;
        chk("rom_address", 32'(rom_address), 32'(exp_addr));
        if (fs) chk("collision_mask", 32'(collision_mask), 32'(mexp));
        if (sb.size() == 3) begin
            e = sb.pop_front();
            chk("pix_hit",   32'(pix_hit),   32'(e.hit));
            chk("pix_index", 32'(pix_index), 32'(e.idx));
            chk("pix_slot",  32'(pix_slot),  32'(e.slot));
            chk("blank_out", 32'(blank_out), 32'(e.blk));
        end
        cfg_we = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic cfg(input int slot, input int field, input int data, input bit fs);
        cfg_we = 1'b1; cfg_slot = 3'(slot); cfg_field = 2'(field);
        cfg_wdata = 10'(data); frame_start = fs;
        DrawX = 10'd0; DrawY = 10'd0; blank = 1'b0;
        step();
    endtask

    task automatic pix(input int x, input int y, input bit b);
        DrawX = 10'(x); DrawY = 10'(y); blank = b;
        step();
    endtask

    task automatic fs_pulse();
        frame_start = 1'b1;
        pix(0, 0, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) pix(0, 0, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        DrawX = 10'd105; DrawY = 10'd60; blank = 1'b1;
        @(posedge vga_clk);
        #1;
        chk("rst_rom_address", 32'(rom_address), 32'd0);
        chk("rst_pix_index",   32'(pix_index),   32'd0);
        chk("rst_pix_hit",     32'(pix_hit),     32'd0);
        chk("rst_pix_slot",    32'(pix_slot),    32'd0);
        chk("rst_blank_out",   32'(blank_out),   32'd0);
        chk("rst_collision",   32'(collision_mask), 32'd0);
        reset = 1'b0;
        clear_model();
    endtask

    initial begin
        reset = 1'b1; DrawX = 10'd0; DrawY = 10'd0; blank = 1'b0;
        frame_start = 1'b0; cfg_we = 1'b0; cfg_slot = 3'd0;
        cfg_field = 2'd0; cfg_wdata = 10'd0;
        clear_model();
        do_reset();

        // Basic fetch: slot 0 at (100,50), image 2.
        cfg(0, 0, 100, 1'b0); cfg(0, 1, 50, 1'b0); cfg(0, 2, 2, 1'b0); cfg(0, 3, 1, 1'b1);
        pix(105, 60, 1'b1);
        chk("tp1_addr", 32'(rom_address), 32'd2373);
        pix(0, 0, 1'b0);
        pix(0, 0, 1'b0);
        chk("tp1_index", 32'(pix_index), 32'h17);
        chk("tp1_hit", 32'(pix_hit), 32'd1);
        drain();

        // Shadow writes stay invisible until frame_start.
        cfg(3, 0, 300, 1'b0); cfg(3, 1, 300, 1'b0); cfg(3, 2, 1, 1'b0); cfg(3, 3, 1, 1'b0);
        pix(305, 305, 1'b1); pix(331, 331, 1'b1); pix(320, 310, 1'b1);
        drain();
        fs_pulse();
        pix(305, 305, 1'b1); pix(331, 331, 1'b1); pix(332, 300, 1'b1);
        drain();

        // Overlap: slot 1 transparent image wins over slot 4.
        cfg(1, 0, 200, 1'b0); cfg(1, 1, 200, 1'b0); cfg(1, 2, 7, 1'b0); cfg(1, 3, 1, 1'b0);
        cfg(4, 0, 210, 1'b0); cfg(4, 1, 210, 1'b0); cfg(4, 2, 1, 1'b0); cfg(4, 3, 1, 1'b1);
        pix(215, 215, 1'b1); pix(205, 205, 1'b1); pix(235, 235, 1'b1);
        drain();
        fs_pulse();
        chk("tp3_collision", 32'(collision_mask), 32'h12);

        // Right-edge no-wrap and exact boundary pixels.
        cfg(5, 0, 1010, 1'b0); cfg(5, 1, 400, 1'b0); cfg(5, 2, 1, 1'b0); cfg(5, 3, 1, 1'b0);
        cfg(6, 0, 500, 1'b0); cfg(6, 1, 100, 1'b0); cfg(6, 2, 3, 1'b0); cfg(6, 3, 1, 1'b1);
        pix(5, 405, 1'b1); pix(1023, 405, 1'b1); pix(531, 131, 1'b1);
        pix(532, 100, 1'b1); pix(499, 100, 1'b1); pix(500, 132, 1'b1);
        drain();

        // Overlap during blanking: no pixel hit, no collision bits.
        pix(215, 215, 1'b0); pix(210, 210, 1'b0);
        drain();
        fs_pulse();
        chk("blank_collision", 32'(collision_mask), 32'd0);

        // Reset mid-scan with pixels in flight, then an empty configuration.
        pix(105, 60, 1'b1); pix(215, 215, 1'b1);
        do_reset();
        pix(105, 60, 1'b1); pix(215, 215, 1'b1); pix(320, 310, 1'b1);
        drain();

        // Write coincident with frame_start is part of the committed set.
        cfg(2, 0, 600, 1'b0); cfg(2, 1, 300, 1'b0); cfg(2, 2, 5, 1'b0); cfg(2, 3, 1, 1'b1);
        pix(610, 310, 1'b1);
        pix(0, 0, 1'b0);
        pix(0, 0, 1'b0);
        chk("coincident_slot", 32'(pix_slot), 32'd2);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sprite_fetch_scheduler.md
Name: sprite_fetch_scheduler

Overview:
- Shares one synchronous 8-bit-index sprite ROM between NUM_SLOTS on-screen sprite slots (tanks, turrets, bullets).
- Per pixel, it finds the highest-priority enabled slot covering (DrawX, DrawY) and issues a single ROM address for it.
- It aligns the returned palette index with delayed blank/hit sideband for the palette/colour stage.
- Slot configuration is double-buffered and committed only at frame start, so sprites never tear mid-frame.

Parameters:
- NUM_SLOTS, 8, number of sprite slots; slot 0 has the highest priority.
- IMG_BITS, 3, log2 of the number of 32x32 images in the ROM.
- SPR_DIM, 32, sprite width and height in pixels; fixed power of two.

Ports:
- vga_clk  in  1  pixel clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- DrawX  in  10  current pixel column.
- DrawY  in  10  current pixel row.
- blank  in  1  1 = active video.
- frame_start  in  1  one-cycle pulse marking the start of a frame; commits shadow config.
- cfg_we  in  1  config write strobe.
- cfg_slot  in  3  slot index; writes to values >= NUM_SLOTS are ignored.
- cfg_field  in  2  selects the field: 0 = x[9:0], 1 = y[9:0], 2 = img[IMG_BITS-1:0], 3 = enable[0].
- cfg_wdata  in  10  write data, LSB-aligned to the selected field.
- rom_address  out  10+IMG_BITS  address = img*1024 + row*32 + col.
- rom_q  in  8  ROM data; valid exactly 1 cycle after rom_address.
- pix_index  out  8  palette index; 0 when there is no hit.
- pix_hit  out  1  an opaque sprite pixel is present.
- pix_slot  out  3  winning slot for pix_index.
- blank_out  out  1  blank delayed to align with pix_*.
- collision_mask  out  NUM_SLOTS  slots that overlapped another opaque-or-not slot during the previous frame.

Behaviour:
- Reset (synchronous, active-high):
  - All shadow and active slots cleared (x = y = img = enable = 0).
  - Pipeline valid bits cleared.
  - rom_address = 0, pix_index = 0, pix_hit = 0, pix_slot = 0, blank_out = 0, collision_mask = 0, collision accumulator = 0.
  - Reset mid-frame discards all in-flight pixels.
- Config:
  - cfg_we writes the shadow field only.
  - On frame_start, active <= shadow for all slots.
  - If cfg_we and frame_start occur in the same cycle, the write is included in the committed value.
  - The active set never changes except at frame_start or reset.
- Hit test, per enabled active slot:
  - Hit when DrawX >= x and DrawX < x+SPR_DIM, and likewise for y.
  - Sums are computed in 11 bits, so a sprite near 1023 does not wrap to column 0.
  - col = DrawX - x and row = DrawY - y, each truncated to 5 bits.
- Arbitration:
  - The lowest-index hitting slot wins.
  - Exactly one ROM read per pixel.
  - A transparent pixel of the winner does NOT fall through to lower-priority slots; this is a documented limitation.
- Pipeline, latency 3 cycles from DrawX/DrawY/blank sampled at edge k:
  - Edge k+1: rom_address, any_hit, slot and blank are registered. rom_address holds its previous value when there is no hit.
  - Edge k+2: ROM presents rom_q; sideband is delayed one more stage.
  - Edge k+3: outputs registered.
    - pix_hit = any_hit & blank_d & (rom_q != 0).
    - pix_index = rom_q if pix_hit, else 0.
    - pix_slot = winner if any_hit, else 0.
    - blank_out = blank_d.
- Collision:
  - Each cycle with blank = 1 and two or more slots hitting, all hitting slots' bits are OR-ed into the accumulator. Transparency is not considered.
  - On frame_start, collision_mask <= accumulator (including that cycle's bits) and the accumulator is cleared.
- Fully pipelined: accepts a new pixel every cycle; no stall or back-pressure.

Test Plan:
- Slot 0 at (100,50), img 2, enable, frame_start; DrawX=105, DrawY=60, blank=1 -> next cycle rom_address = 2*1024 + 10*32 + 5 = 2373; with rom_q = 0x17, after 3 cycles pix_index = 0x17, pix_hit = 1, pix_slot = 0, blank_out = 1.
- Write slot 3 enable without frame_start; scan its area -> pix_hit = 0. After a frame_start pulse -> hits reported with pix_slot = 3.
- Slots 1 and 4 overlapping at (200,200) -> pix_slot = 1. rom_q = 0 -> pix_hit = 0, pix_index = 0 (no fall-through to slot 4). After the next frame_start, collision_mask = 0b00010010.
- Slot at x = 1010 and DrawX = 5 -> no hit (no wrap). Edge checks: DrawX = x+31 hits, DrawX = x+32 misses.
- Hit with blank = 0 -> pix_hit = 0, blank_out = 0, and no collision bits set.
- Assert reset mid-scan with config loaded -> next cycle all outputs 0. After deassert with no config, all pixels have pix_hit = 0. cfg_we coincident with frame_start -> the new value is active in the same frame.
